// File: rtl/reu_regfile_if.sv
// CPU-side bus and sequencer handshake of the REU register file.
// The slave modport is the register file; the master modport is the system side.
interface reu_regfile_if #(
  parameter int REU_ABITS = 19
);
  logic [15:0]          A;
  logic                 nIO2;
  logic                 RnW;
  logic [7:0]           Din;
  logic [7:0]           Dout;
  logic                 DoutOE;
  logic                 DMA;
  logic                 NextCA;
  logic                 NextREUA;
  logic                 XferEnd;
  logic                 VerifyErr;
  logic                 Execute;
  logic [1:0]           XferType;
  logic                 Length1;
  logic [15:0]          CA;
  logic [REU_ABITS-1:0] REUA;
  logic                 nIRQ;

  modport slave (
    input  A, nIO2, RnW, Din, DMA, NextCA, NextREUA, XferEnd, VerifyErr,
    output Dout, DoutOE, Execute, XferType, Length1, CA, REUA, nIRQ
  );

  modport master (
    output A, nIO2, RnW, Din, DMA, NextCA, NextREUA, XferEnd, VerifyErr,
    input  Dout, DoutOE, Execute, XferType, Length1, CA, REUA, nIRQ
  );
endinterface

// File: rtl/reu_regfile.sv
// REU register file at $DF00-$DF1F: address/length counters with autoload shadows,
// command/mask/addrctl/status registers, and Execute generation for the DMA sequencer.
module reu_regfile #(
  parameter int         REU_ABITS = 19,
  parameter logic [3:0] VERSION   = 4'd0
) (
  input  logic          PHI2,
  input  logic          nRESET,
  reu_regfile_if.slave  bus
);

  localparam logic [REU_ABITS-1:0] RA_ONE    = {{(REU_ABITS-1){1'b0}}, 1'b1};
  localparam logic [7:0]           BANK_MASK = 8'((1 << (REU_ABITS - 16)) - 1);
  localparam logic                 BIG_REU   = (REU_ABITS > 17);

  logic [15:0]          ca, ca_sh;
  logic [REU_ABITS-1:0] reua, reua_sh;
  logic [15:0]          len, len_sh;
  logic [7:0]           cmd;
  logic [2:0]           mask;      // mask[7:5]
  logic [1:0]           addrctl;   // addrctl[7:6]
  logic                 st_eob, st_fault;
  logic                 armed;
  logic                 exec_q;
  logic                 reua_reload;

  logic [4:0]  reg_sel;
  logic        wr_en, rd_status, ff00_hit, irq, autoload, xfer_done;
  logic [23:0] reua24;
  logic [7:0]  bank_rd;

  assign reg_sel   = bus.A[4:0];
  assign wr_en     = !bus.nIO2 && !bus.RnW && !bus.DMA && !exec_q;
  assign rd_status = !bus.nIO2 &&  bus.RnW && !bus.DMA && (reg_sel == 5'h00);
  assign ff00_hit  = armed && (bus.A == 16'hFF00) && !bus.RnW && !bus.DMA && !exec_q;
  assign irq       = mask[2] && ((st_eob && mask[1]) || (st_fault && mask[0]));
  assign xfer_done = bus.XferEnd || bus.VerifyErr;
  assign autoload  = bus.XferEnd && !bus.VerifyErr && cmd[5];

  assign reua24  = 24'(reua);
  assign bank_rd = reua24[23:16] | ~BANK_MASK;

  assign bus.DoutOE   = !bus.nIO2 && bus.RnW && !bus.DMA;
  assign bus.Execute  = exec_q;
  assign bus.XferType = cmd[1:0];
  assign bus.Length1  = (len == 16'd1);
  assign bus.CA       = ca;
  assign bus.REUA     = reua;
  assign bus.nIRQ     = !irq;

  // Unimplemented bits read back as 1, as on the original REU.
  always_comb begin
    bus.Dout = 8'hFF;
    case (reg_sel)
      5'h00: bus.Dout = {irq, st_eob, st_fault, BIG_REU, VERSION};
      5'h01: bus.Dout = cmd | 8'b0100_1100;
      5'h02: bus.Dout = ca[7:0];
      5'h03: bus.Dout = ca[15:8];
      5'h04: bus.Dout = reua[7:0];
      5'h05: bus.Dout = reua[15:8];
      5'h06: bus.Dout = bank_rd;
      5'h07: bus.Dout = len[7:0];
      5'h08: bus.Dout = len[15:8];
      5'h09: bus.Dout = {mask, 5'b1_1111};
      5'h0A: bus.Dout = {addrctl, 6'b11_1111};
      default: bus.Dout = 8'hFF;
    endcase
  end

  // Later statements override earlier ones: CPU write, counter step, end-of-transfer, reload.
  always_ff @(negedge PHI2 or negedge nRESET) begin
    if (!nRESET) begin
      ca          <= 16'h0000;
      ca_sh       <= 16'h0000;
      reua        <= '0;
      reua_sh     <= '0;
      len         <= 16'hFFFF;
      len_sh      <= 16'hFFFF;
      cmd         <= 8'h10;
      mask        <= 3'b000;
      addrctl     <= 2'b00;
      st_eob      <= 1'b0;
      st_fault    <= 1'b0;
      armed       <= 1'b0;
      exec_q      <= 1'b0;
      reua_reload <= 1'b0;
    end else begin
      reua_reload <= 1'b0;

      if (wr_en) begin
        case (reg_sel)
          5'h01: begin
            cmd   <= bus.Din & 8'b1011_0011;
            armed <= bus.Din[7] && !bus.Din[4];
            if (bus.Din[7] && bus.Din[4]) exec_q <= 1'b1;
          end
          5'h02: begin ca[7:0]   <= bus.Din; ca_sh[7:0]   <= bus.Din; end
          5'h03: begin ca[15:8]  <= bus.Din; ca_sh[15:8]  <= bus.Din; end
          5'h04: begin reua[7:0] <= bus.Din; reua_sh[7:0] <= bus.Din; end
          5'h05: begin reua[15:8] <= bus.Din; reua_sh[15:8] <= bus.Din; end
          5'h06: begin
            reua[REU_ABITS-1:16]    <= bus.Din[REU_ABITS-17:0];
            reua_sh[REU_ABITS-1:16] <= bus.Din[REU_ABITS-17:0];
          end
          5'h07: begin len[7:0]  <= bus.Din; len_sh[7:0]  <= bus.Din; end
          5'h08: begin len[15:8] <= bus.Din; len_sh[15:8] <= bus.Din; end
          5'h09: mask    <= bus.Din[7:5];
          5'h0A: addrctl <= bus.Din[7:6];
          default: ;
        endcase
      end

      if (ff00_hit) begin
        exec_q <= 1'b1;
        armed  <= 1'b0;
      end

      // LEN parks at 1 so the sequencer keeps seeing Length1 on the last byte.
      if (bus.NextCA) begin
        if (!addrctl[1]) ca <= ca + 16'd1;
        if (len != 16'd1) len <= len - 16'd1;
      end
      if (bus.NextREUA && !addrctl[0]) reua <= reua + RA_ONE;

      if (rd_status) begin
        st_eob   <= 1'b0;
        st_fault <= 1'b0;
      end
      if (bus.XferEnd)   st_eob   <= 1'b1;
      if (bus.VerifyErr) st_fault <= 1'b1;
      if (xfer_done) begin
        exec_q <= 1'b0;
        cmd[7] <= 1'b0;
      end

      // Stash (type 00) issues its last REU write one edge late, so its reload is deferred.
      if (autoload) begin
        ca  <= ca_sh;
        len <= len_sh;
        if (cmd[1:0] != 2'b00) reua <= reua_sh;
        else                   reua_reload <= 1'b1;
      end
      if (reua_reload) reua <= reua_sh;
    end
  end

endmodule

// File: tb/tb_reu_regfile.sv
// Directed bench for reu_regfile: stimulus pushes expected values into a queue,
// a monitor pops and compares them at the rising PHI2 edge or on an explicit kick.
module tb_reu_regfile;
  localparam int RA = 19;
  localparam int S_DOUT = 0, S_EXEC = 1, S_NIRQ = 2, S_CA = 3, S_REUA = 4, S_LEN1 = 5, S_TYPE = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [23:0] exp;
    string       name;
  } exp_t;

  logic PHI2   = 1'b1;
  logic nRESET = 1'b0;
  logic kick   = 1'b0;
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  exp_t q[$];

  reu_regfile_if #(.REU_ABITS(RA)) bus();
  reu_regfile #(.REU_ABITS(RA), .VERSION(4'd0)) dut (.PHI2(PHI2), .nRESET(nRESET), .bus(bus));

  always #5 PHI2 = ~PHI2;
  always @(negedge PHI2) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [23:0] probe(int sel);
    case (sel)
      S_DOUT:  return 24'(bus.Dout);
      S_EXEC:  return 24'(bus.Execute);
      S_NIRQ:  return 24'(bus.nIRQ);
      S_CA:    return 24'(bus.CA);
      S_REUA:  return 24'(bus.REUA);
      S_LEN1:  return 24'(bus.Length1);
      default: return 24'(bus.XferType);
    endcase
  endfunction

  always @(posedge PHI2 or posedge kick) begin
    exp_t        e;
    logic [23:0] got;
    while (q.size() != 0 && q[0].cyc <= cyc_cnt) begin
      e   = q.pop_front();
      got = probe(e.sel);
      n_chk++;
      if (e.sel == S_DOUT && !bus.DoutOE) begin
        n_fail++;
        $display("FAIL %s: DoutOE=0, want DoutOE=1 with data %0h", e.name, e.exp);
      end else if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h want %0h", e.name, got, e.exp);
      end
    end
  end

  task automatic expect_v(int sel, logic [23:0] v, string name);
    exp_t e;
    e.cyc = cyc_cnt; e.sel = sel; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge PHI2);
    #1;
  endtask

  task automatic idle();
    bus.A = 16'h0000; bus.nIO2 = 1'b1; bus.RnW = 1'b1; bus.Din = 8'h00; bus.DMA = 1'b0;
    bus.NextCA = 1'b0; bus.NextREUA = 1'b0; bus.XferEnd = 1'b0; bus.VerifyErr = 1'b0;
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    idle();
    bus.A = a; bus.nIO2 = (a[15:8] != 8'hDF); bus.RnW = 1'b0; bus.Din = d;
    tick();
    idle();
  endtask

  task automatic rd(logic [4:0] r, logic [7:0] v, string name);
    idle();
    bus.A = 16'hDF00 | 16'(r); bus.nIO2 = 1'b0; bus.RnW = 1'b1;
    expect_v(S_DOUT, 24'(v), name);
    tick();
    idle();
  endtask

  task automatic dma(logic nca, logic nra, logic xe, logic ve);
    idle();
    bus.DMA = 1'b1; bus.NextCA = nca; bus.NextREUA = nra; bus.XferEnd = xe; bus.VerifyErr = ve;
    tick();
    idle();
  endtask

  task automatic load(logic [15:0] c, logic [23:0] r, logic [15:0] l);
    wr(16'hDF02, c[7:0]);  wr(16'hDF03, c[15:8]);
    wr(16'hDF04, r[7:0]);  wr(16'hDF05, r[15:8]); wr(16'hDF06, r[23:16]);
    wr(16'hDF07, l[7:0]);  wr(16'hDF08, l[15:8]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_tab [0:11];
    rst_tab = '{8'h10, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'hFF, 8'hFF, 8'h1F, 8'h3F, 8'hFF};
    idle();
    repeat (2) @(negedge PHI2);
    #3 nRESET = 1'b1;
    tick();

    // Reset state
    expect_v(S_EXEC, 0, "rst execute");
    expect_v(S_NIRQ, 1, "rst nirq");
    for (int i = 0; i < 12; i++) rd(5'(i), rst_tab[i], $sformatf("rst reg %0h", i));
    rd(5'h1F, 8'hFF, "rst reg 1f");

    // Plain transfer, no autoload
    load(16'h0400, 24'h000100, 16'h0003);
    rd(5'h07, 8'h03, "t2 len lo");
    rd(5'h05, 8'h01, "t2 reua hi");
    wr(16'hDF01, 8'h90);
    expect_v(S_EXEC, 1, "t2 execute");
    wr(16'hDF02, 8'hAA);
    rd(5'h02, 8'h00, "t2 write blocked");
    dma(1, 1, 0, 0);
    dma(1, 1, 0, 0);
    expect_v(S_LEN1, 1, "t2 length1");
    dma(1, 1, 1, 0);
    expect_v(S_CA, 24'h0403, "t2 ca");
    expect_v(S_REUA, 24'h000103, "t2 reua");
    expect_v(S_EXEC, 0, "t2 execute end");
    expect_v(S_LEN1, 1, "t2 len holds 1");
    rd(5'h07, 8'h01, "t2 len lo end");
    rd(5'h08, 8'h00, "t2 len hi end");
    rd(5'h00, 8'h50, "t2 status");
    rd(5'h00, 8'h10, "t2 status cleared");

    // Autoload, type 00 with lagging NextREUA
    load(16'h0400, 24'h000100, 16'h0003);
    wr(16'hDF01, 8'hB0);
    expect_v(S_EXEC, 1, "t3 execute");
    dma(1, 0, 0, 0);
    dma(1, 1, 0, 0);
    dma(1, 1, 1, 0);
    expect_v(S_CA, 24'h0400, "t3 ca reload");
    expect_v(S_REUA, 24'h000102, "t3 reua before reload");
    expect_v(S_EXEC, 0, "t3 execute end");
    dma(0, 1, 0, 0);
    expect_v(S_REUA, 24'h000100, "t3 reua reload");
    rd(5'h07, 8'h03, "t3 len reload");
    rd(5'h08, 8'h00, "t3 len hi reload");
    rd(5'h00, 8'h50, "t3 status");

    // $FF00 trigger
    wr(16'hDF01, 8'h80);
    expect_v(S_EXEC, 0, "t4 armed no exec");
    wr(16'hDF01, 8'h80);
    expect_v(S_EXEC, 0, "t4 rewrite no exec");
    wr(16'hFF00, 8'h00);
    expect_v(S_EXEC, 1, "t4 ff00 exec");
    dma(0, 0, 1, 0);
    expect_v(S_EXEC, 0, "t4 execute end");
    rd(5'h01, 8'h4C, "t4 cmd7 cleared");
    rd(5'h00, 8'h50, "t4 status");

    // Verify error with IRQ
    wr(16'hDF09, 8'hE0);
    rd(5'h09, 8'hFF, "t5 mask");
    wr(16'hDF07, 8'h05);
    wr(16'hDF08, 8'h00);
    wr(16'hDF01, 8'h93);
    expect_v(S_TYPE, 3, "t5 xfertype");
    expect_v(S_EXEC, 1, "t5 execute");
    dma(1, 0, 0, 1);
    expect_v(S_EXEC, 0, "t5 execute end");
    expect_v(S_NIRQ, 0, "t5 nirq low");
    expect_v(S_LEN1, 0, "t5 length1");
    rd(5'h07, 8'h04, "t5 len");
    rd(5'h01, 8'h5F, "t5 cmd");
    rd(5'h00, 8'hB0, "t5 status");
    expect_v(S_NIRQ, 1, "t5 nirq cleared");
    rd(5'h00, 8'h10, "t5 status cleared");

    // REUA wrap, fixed CA, async reset mid-transfer
    load(16'h1234, 24'h07FFFF, 16'h0010);
    rd(5'h06, 8'hFF, "t6 bank");
    wr(16'hDF0A, 8'h80);
    rd(5'h0A, 8'hBF, "t6 addrctl");
    wr(16'hDF01, 8'h90);
    dma(1, 1, 0, 0);
    expect_v(S_REUA, 24'h000000, "t6 reua wrap");
    expect_v(S_CA, 24'h1234, "t6 ca fixed");
    expect_v(S_EXEC, 1, "t6 execute");
    @(posedge PHI2);
    #1 nRESET = 1'b0;
    #1;
    expect_v(S_EXEC, 0, "t6 async execute");
    expect_v(S_CA, 24'h0000, "t6 async ca");
    expect_v(S_REUA, 24'h000000, "t6 async reua");
    kick = 1'b1;
    #1 kick = 1'b0;
    #1 nRESET = 1'b1;
    tick();
    rd(5'h07, 8'hFF, "t6 len lo reset");
    rd(5'h08, 8'hFF, "t6 len hi reset");
    rd(5'h0A, 8'h3F, "t6 addrctl reset");
    rd(5'h01, 8'h5C, "t6 cmd reset");

    repeat (3) tick();
    if (q.size() != 0) begin
      n_fail += q.size();
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
